resp_serializer: RTL and testbench
==================================

# resp_serializer

Response-side serializer for the UART command path. Pops completed `cmd_packet_t` responses from the command response FIFO, the one written by the dispatcher via `cmd_resp_wr_en`/`cmd_resp_wr_data`. Frames each response as a fixed-length byte sequence with a start-of-frame byte and an XOR checksum. Streams the bytes to the UART transmitter over a valid/ready byte handshake.

## Interface

Parameters:
- `SOF_BYTE`, default 8'hA5: start-of-frame byte emitted first in every frame.
- `ADD_CHECKSUM`, default 1: 1 appends the checksum byte (6-byte frame); 0 omits it (5-byte frame).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - `clk`  in  1  clock.
  - `rst`  in  1  synchronous active-high reset.
- Response FIFO side (first-word fall-through):
  - `resp_fifo_valid`  in  1  FIFO non-empty; `resp_fifo_data` is valid.
  - `resp_fifo_data`  in  `cmd_packet_t`  head-of-FIFO response.
  - `resp_fifo_rd_en`  out  1  single-cycle pop strobe.
- UART transmitter side:
  - `tx_byte_valid`  out  1  `tx_byte_data` holds a byte to send.
  - `tx_byte_data`  out  8  byte to send.
  - `tx_byte_ready`  in  1  transmitter accepts the byte this cycle.
- Status:
  - `busy`  out  1  high while a frame is in flight.
  - `pkt_sent`  out  1  one-cycle pulse when a frame's last byte is accepted.
  - `pkt_count`  out  16  frames sent; wraps 16'hFFFF -> 0.

## Operation

- `cmd_packet_t` is a packed 32-bit struct, MSB first: `opcode[7:0]`, `addr[7:0]`, `data[7:0]`, `status[7:0]`.
- Frame byte order (index 0..5): `SOF_BYTE`, `opcode`, `addr`, `data`, `status`, `chk`.
  - `chk = opcode ^ addr ^ data ^ status`. `SOF_BYTE` is excluded.
  - Last index is 5 when `ADD_CHECKSUM`=1, otherwise 4.
- FSM states: IDLE and SEND.
  - IDLE: when `resp_fifo_valid`=1, assert `resp_fifo_rd_en` for that cycle. Latch `resp_fifo_data` and the computed `chk` into a frame register, set `byte_idx`=0, and go to SEND.
  - SEND: `tx_byte_valid`=1 and `tx_byte_data` = frame byte selected by `byte_idx`.
    - On `tx_byte_valid & tx_byte_ready` with `byte_idx` < last: increment `byte_idx`.
    - On acceptance of the last byte: pulse `pkt_sent` and increment `pkt_count`. Then:
      - if `resp_fifo_valid`=1 in that same cycle: pop (`resp_fifo_rd_en`=1), latch the new packet, set `byte_idx`=0, and stay in SEND (back-to-back frames);
      - otherwise go to IDLE.
- `resp_fifo_rd_en` is asserted only in IDLE or on a last-byte acceptance, and never when `resp_fifo_valid`=0.
- `busy` = (state == SEND).

## Timing

- Reset values: all outputs 0, state IDLE, `byte_idx` 0, frame register 0.
- Latency: pop in cycle N -> `tx_byte_valid`=1 with the SOF byte in cycle N+1.
- Handshake rules:
  - Once `tx_byte_valid` is asserted, `tx_byte_valid` and `tx_byte_data` stay stable until accepted.
  - `tx_byte_ready` may stay low indefinitely; the block simply stalls.
  - `tx_byte_ready` is ignored while `tx_byte_valid`=0.
- Throughput:
  - With `tx_byte_ready` held high, one byte per cycle.
  - Back-to-back frames have zero idle cycles between them: the SOF of frame k+1 follows the last byte of frame k on the next cycle.
- Upstream writes never interrupt a frame in flight. Changes to `resp_fifo_data` mid-frame have no effect because the data is latched at pop.
- Reset mid-frame: the frame is abandoned with no further bytes. `tx_byte_valid` is 0 on the cycle after `rst`. The popped packet is lost, which is accepted behaviour. `pkt_count` returns to 0.
- `pkt_sent` and a new pop can occur in the same cycle.

## Structure

- `cmd_packet_t` belongs in the shared command package, alongside the packet definitions used by the parser and dispatcher.
- Also in that package: the frame length constants `RESP_FRAME_LEN_CHK`=6 and `RESP_FRAME_LEN_NOCHK`=5, and the `SOF_BYTE` default.
- Single module, no sub-modules. The checksum is a 4-input XOR computed combinationally from `resp_fifo_data` and registered at pop.
- The existing `cmd_execute_if` is extended, or a sibling `resp_serializer_if` is added, carrying the FIFO-side and TX-side signals for the bench.

## Test plan

- Single frame, ready tied high: push {opcode 8'h02, addr 8'h10, data 8'h5A, status 8'h00} -> bytes A5,02,10,5A,00,48 on six consecutive cycles, starting one cycle after the pop. One `pkt_sent` pulse; `pkt_count`=1.
- Backpressure: same packet with `tx_byte_ready` toggling 1,0,0,1,... -> identical byte sequence. Each byte is held stable while ready=0; no byte is duplicated or dropped.
- Back-to-back: three packets preloaded, ready high -> 18 bytes with no gaps, exactly three pops, and `pkt_count`=3.
- `ADD_CHECKSUM`=0: packet {01,20,FF,01} -> bytes A5,01,20,FF,01 only, then return to IDLE.
- Reset mid-frame: assert `rst` after byte 2 is accepted -> `tx_byte_valid`=0, `busy`=0, and `pkt_count`=0 the next cycle. A following packet produces a fresh full frame starting at A5.
- Empty FIFO: `resp_fifo_valid`=0 for 100 cycles -> `resp_fifo_rd_en` and `tx_byte_valid` never assert.

Source files
------------

// File: rtl/resp_serializer_pkg.sv
// Shared command-path definitions: packet layout, response frame
// constants and the response checksum helper.
package resp_serializer_pkg;

    typedef struct packed {
        logic [7:0] opcode;
        logic [7:0] addr;
        logic [7:0] data;
        logic [7:0] status;
    } cmd_packet_t;

    localparam int         RESP_FRAME_LEN_CHK   = 6;
    localparam int         RESP_FRAME_LEN_NOCHK = 5;
    localparam logic [7:0] RESP_SOF_BYTE        = 8'hA5;

    // SOF is deliberately not part of the checksum
    function automatic logic [7:0] resp_chk(input cmd_packet_t p);
        return p.opcode ^ p.addr ^ p.data ^ p.status;
    endfunction

endpackage

// File: rtl/resp_serializer_if.sv
// FIFO-side and TX-side bundle around the response serializer.
// Lets a bench or the UART wrapper carry the whole path as one port.
interface resp_serializer_if (
    input logic clk
);
    import resp_serializer_pkg::*;

    logic        resp_fifo_valid;
    cmd_packet_t resp_fifo_data;
    logic        resp_fifo_rd_en;
    logic        tx_byte_valid;
    logic [7:0]  tx_byte_data;
    logic        tx_byte_ready;
    logic        busy;
    logic        pkt_sent;
    logic [15:0] pkt_count;

    modport dut (
        input  clk,
        input  resp_fifo_valid,
        input  resp_fifo_data,
        output resp_fifo_rd_en,
        output tx_byte_valid,
        output tx_byte_data,
        input  tx_byte_ready,
        output busy,
        output pkt_sent,
        output pkt_count
    );

    modport tb (
        input  clk,
        output resp_fifo_valid,
        output resp_fifo_data,
        input  resp_fifo_rd_en,
        input  tx_byte_valid,
        input  tx_byte_data,
        output tx_byte_ready,
        input  busy,
        input  pkt_sent,
        input  pkt_count
    );

endinterface

// File: rtl/resp_serializer.sv
// Pops command responses and streams each one as a SOF-framed byte
// sequence (optional XOR checksum) over a valid/ready byte port.
module resp_serializer
    import resp_serializer_pkg::*;
#(
    parameter logic [7:0] SOF_BYTE     = RESP_SOF_BYTE,
    parameter bit         ADD_CHECKSUM = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        resp_fifo_valid,
    input  cmd_packet_t resp_fifo_data,
    output logic        resp_fifo_rd_en,
    output logic        tx_byte_valid,
    output logic [7:0]  tx_byte_data,
    input  logic        tx_byte_ready,
    output logic        busy,
    output logic        pkt_sent,
    output logic [15:0] pkt_count
);

    localparam int LAST_INT = (ADD_CHECKSUM ? RESP_FRAME_LEN_CHK
                                            : RESP_FRAME_LEN_NOCHK) - 1;
    localparam logic [2:0] LAST_IDX = 3'(LAST_INT);

    typedef enum logic {
        S_IDLE,
        S_SEND
    } state_t;

    state_t      r_state;
    cmd_packet_t r_frame;
    logic [7:0]  r_chk;
    logic [2:0]  r_idx;
    logic [15:0] r_pkt_count;

    logic       w_send;
    logic       w_accept;
    logic       w_last_acc;
    logic       w_pop;
    logic [7:0] w_byte;

    // rst gates the combinational outputs so they read 0 during reset
    assign w_send     = (r_state == S_SEND) && !rst;
    assign w_accept   = w_send && tx_byte_ready;
    assign w_last_acc = w_accept && (r_idx == LAST_IDX);
    assign w_pop      = !rst && resp_fifo_valid &&
                        ((r_state == S_IDLE) || w_last_acc);

    always_comb begin
        w_byte = SOF_BYTE;
        case (r_idx)
            3'd1:    w_byte = r_frame.opcode;
            3'd2:    w_byte = r_frame.addr;
            3'd3:    w_byte = r_frame.data;
            3'd4:    w_byte = r_frame.status;
            3'd5:    w_byte = r_chk;
            default: w_byte = SOF_BYTE;
        endcase
    end

    assign resp_fifo_rd_en = w_pop;
    assign tx_byte_valid   = w_send;
    assign tx_byte_data    = w_send ? w_byte : 8'h00;
    assign busy            = w_send;
    assign pkt_sent        = w_last_acc;
    assign pkt_count       = r_pkt_count;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_frame     <= '0;
            r_chk       <= 8'h00;
            r_idx       <= 3'd0;
            r_pkt_count <= 16'h0000;
        end else begin
            if (w_accept && !w_last_acc) begin
                r_idx <= r_idx + 3'd1;
            end
            if (w_last_acc) begin
                r_pkt_count <= r_pkt_count + 16'd1;
                r_state     <= S_IDLE;
            end
            // a pop on the last byte overrides the IDLE return above
            if (w_pop) begin
                r_frame <= resp_fifo_data;
                r_chk   <= resp_chk(resp_fifo_data);
                r_idx   <= 3'd0;
                r_state <= S_SEND;
            end
        end
    end

endmodule

// File: tb/tb_resp_serializer.sv
// Self-checking bench for resp_serializer: vector table, corner
// sequences and random traffic against a queue-based frame model.
`timescale 1ns/1ps
module tb_resp_serializer;
    import resp_serializer_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;
    resp_serializer_if bus (.clk(clk));

    resp_serializer u_dut (
        .clk             (clk),
        .rst             (rst),
        .resp_fifo_valid (bus.resp_fifo_valid),
        .resp_fifo_data  (bus.resp_fifo_data),
        .resp_fifo_rd_en (bus.resp_fifo_rd_en),
        .tx_byte_valid   (bus.tx_byte_valid),
        .tx_byte_data    (bus.tx_byte_data),
        .tx_byte_ready   (bus.tx_byte_ready),
        .busy            (bus.busy),
        .pkt_sent        (bus.pkt_sent),
        .pkt_count       (bus.pkt_count)
    );

    logic        n_valid;
    cmd_packet_t n_data;
    logic        n_rd_en;
    logic        n_tx_valid;
    logic [7:0]  n_tx_data;
    logic        n_ready;
    logic        n_busy;
    logic        n_sent;
    logic [15:0] n_count;

    resp_serializer #(.ADD_CHECKSUM(1'b0)) u_nochk (
        .clk             (clk),
        .rst             (rst),
        .resp_fifo_valid (n_valid),
        .resp_fifo_data  (n_data),
        .resp_fifo_rd_en (n_rd_en),
        .tx_byte_valid   (n_tx_valid),
        .tx_byte_data    (n_tx_data),
        .tx_byte_ready   (n_ready),
        .busy            (n_busy),
        .pkt_sent        (n_sent),
        .pkt_count       (n_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // reference model state
    cmd_packet_t fifo_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    int          model_count = 0;
    int          pop_cnt = 0;
    int          cyc = 0;
    int          pop_cyc = -1;
    int          first_acc = -1;
    int          last_acc = -1;
    int          rdy_mode = 0;
    int          tgl = 0;
    bit          pop_pending = 0;
    bit          prev_valid = 0;
    bit          prev_ready = 0;
    bit          prev_pop = 0;
    bit          prev_rst = 0;
    logic [7:0]  prev_data = 8'h00;

    task automatic push_frame(input cmd_packet_t p);
        exp_q.push_back(8'hA5);
        exp_q.push_back(p.opcode);
        exp_q.push_back(p.addr);
        exp_q.push_back(p.data);
        exp_q.push_back(p.status);
        exp_q.push_back(p.opcode ^ p.addr ^ p.data ^ p.status);
    endtask

    task automatic refresh();
        bus.resp_fifo_valid = (fifo_q.size() != 0);
        if (fifo_q.size() != 0) bus.resp_fifo_data = fifo_q[0];
        else                    bus.resp_fifo_data = cmd_packet_t'($urandom);
    endtask

    task automatic monitor();
        bit acc, exp_sent, exp_rd;
        if (rst) begin
            check("rst_tx_valid", bus.tx_byte_valid, 1'b0);
            check("rst_rd_en", bus.resp_fifo_rd_en, 1'b0);
            check("rst_pkt_sent", bus.pkt_sent, 1'b0);
            exp_q.delete();
            model_count = 0;
            prev_valid  = 0;
            prev_pop    = 0;
            prev_rst    = 1;
            return;
        end
        check("tx_valid", bus.tx_byte_valid, exp_q.size() != 0);
        check("busy", bus.busy, exp_q.size() != 0);
        if (prev_valid && !prev_ready)
            check("hold_data", bus.tx_byte_data, prev_data);
        if (prev_pop)
            check("sof_after_pop", bus.tx_byte_data, 8'hA5);
        acc      = (exp_q.size() != 0) && bus.tx_byte_ready;
        exp_sent = acc && (exp_q.size() == 1);
        exp_rd   = (fifo_q.size() != 0) &&
                   ((exp_q.size() == 0) || exp_sent);
        check("rd_en", bus.resp_fifo_rd_en, exp_rd);
        check("pkt_sent", bus.pkt_sent, exp_sent);
        check("pkt_count", bus.pkt_count, model_count[15:0]);
        if (acc) begin
            check("tx_byte", bus.tx_byte_data, exp_q[0]);
            cap_q.push_back(bus.tx_byte_data);
            void'(exp_q.pop_front());
            if (first_acc < 0) first_acc = cyc;
            last_acc = cyc;
        end
        if (exp_sent) model_count = (model_count + 1) & 16'hFFFF;
        prev_pop = 0;
        if (bus.resp_fifo_rd_en && fifo_q.size() != 0) begin
            push_frame(fifo_q[0]);
            pop_pending = 1;
            pop_cnt++;
            pop_cyc  = cyc;
            prev_pop = 1;
        end
        prev_valid = bus.tx_byte_valid;
        prev_ready = bus.tx_byte_ready;
        prev_data  = bus.tx_byte_data;
        prev_rst   = 0;
    endtask

    task automatic cycle();
        @(negedge clk);
        monitor();
        @(posedge clk);
        #1;
        if (pop_pending) begin
            void'(fifo_q.pop_front());
            pop_pending = 0;
        end
        refresh();
        cyc++;
        tgl++;
        case (rdy_mode)
            0:       bus.tx_byte_ready = 1'b1;
            1:       bus.tx_byte_ready = (tgl % 3 == 0);
            2:       bus.tx_byte_ready = 1'($urandom_range(0, 1));
            default: bus.tx_byte_ready = 1'b0;
        endcase
    endtask

    task automatic drain(input int budget);
        int n = 0;
        while ((fifo_q.size() != 0 || exp_q.size() != 0) && n < budget) begin
            cycle();
            n++;
        end
        check("drain_done", n < budget, 1'b1);
        cycle();
    endtask

    typedef struct {
        cmd_packet_t pkt;
        logic [47:0] frame;
        int          mode;
    } vec_t;

    vec_t vecs[6];

    initial begin
        int pops0, cnt0, pushed;
        logic [47:0] b2b;

        vecs[0] = '{'{8'h02, 8'h10, 8'h5A, 8'h00}, 48'hA5_02_10_5A_00_48, 0};
        vecs[1] = '{'{8'h01, 8'h20, 8'hFF, 8'h01}, 48'hA5_01_20_FF_01_DF, 0};
        vecs[2] = '{'{8'hFF, 8'hFF, 8'hFF, 8'hFF}, 48'hA5_FF_FF_FF_FF_00, 0};
        vecs[3] = '{'{8'h12, 8'h34, 8'h56, 8'h78}, 48'hA5_12_34_56_78_08, 2};
        vecs[4] = '{'{8'h80, 8'h01, 8'h00, 8'h00}, 48'hA5_80_01_00_00_81, 0};
        vecs[5] = '{'{8'h02, 8'h10, 8'h5A, 8'h00}, 48'hA5_02_10_5A_00_48, 1};

        rst = 1'b1;
        bus.resp_fifo_valid = 1'b0;
        bus.resp_fifo_data  = '0;
        bus.tx_byte_ready   = 1'b1;
        n_valid = 1'b0;
        n_data  = '0;
        n_ready = 1'b1;

        cycle();
        cycle();
        rst = 1'b0;
        check("reset_count", bus.pkt_count, 16'h0000);
        check("reset_valid", bus.tx_byte_valid, 1'b0);
        check("reset_busy", bus.busy, 1'b0);
        check("reset_data", bus.tx_byte_data, 8'h00);
        cycle();

        for (int v = 0; v < 6; v++) begin
            rdy_mode  = vecs[v].mode;
            cap_q.delete();
            first_acc = -1;
            pops0 = pop_cnt;
            cnt0  = bus.pkt_count;
            fifo_q.push_back(vecs[v].pkt);
            refresh();
            drain(200);
            check("vec_len", cap_q.size(), 6);
            for (int i = 0; i < 6 && i < cap_q.size(); i++)
                check($sformatf("vec%0d_byte%0d", v, i), cap_q[i],
                      vecs[v].frame[47-8*i -: 8]);
            check("vec_pops", pop_cnt - pops0, 1);
            check("vec_count", bus.pkt_count, 16'(cnt0 + 1));
            if (vecs[v].mode == 0)
                check("vec_latency", first_acc - pop_cyc, 1);
        end

        // back-to-back frames, no gaps
        rdy_mode = 0;
        cap_q.delete();
        first_acc = -1;
        pops0 = pop_cnt;
        cnt0  = bus.pkt_count;
        for (int v = 1; v < 4; v++) fifo_q.push_back(vecs[v].pkt);
        refresh();
        drain(200);
        check("b2b_len", cap_q.size(), 18);
        check("b2b_span", last_acc - first_acc, 17);
        check("b2b_pops", pop_cnt - pops0, 3);
        check("b2b_count", bus.pkt_count, 16'(cnt0 + 3));
        for (int v = 1; v < 4; v++) begin
            b2b = vecs[v].frame;
            for (int i = 0; i < 6 && (v-1)*6+i < cap_q.size(); i++)
                check("b2b_byte", cap_q[(v-1)*6+i], b2b[47-8*i -: 8]);
        end

        // reset in the middle of a frame
        rdy_mode = 0;
        cap_q.delete();
        fifo_q.push_back(vecs[0].pkt);
        refresh();
        for (int n = 0; n < 20 && cap_q.size() < 3; n++) cycle();
        check("mid_bytes_before_rst", cap_q.size(), 3);
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        check("mid_rst_valid", bus.tx_byte_valid, 1'b0);
        check("mid_rst_busy", bus.busy, 1'b0);
        check("mid_rst_count", bus.pkt_count, 16'h0000);
        cycle();
        cap_q.delete();
        fifo_q.push_back(vecs[4].pkt);
        refresh();
        drain(200);
        check("mid_fresh_len", cap_q.size(), 6);
        for (int i = 0; i < 6 && i < cap_q.size(); i++)
            check("mid_fresh_byte", cap_q[i], vecs[4].frame[47-8*i -: 8]);
        check("mid_fresh_count", bus.pkt_count, 16'h0001);

        // empty FIFO for 100 cycles
        rdy_mode = 2;
        pops0 = pop_cnt;
        cap_q.delete();
        for (int n = 0; n < 100; n++) cycle();
        check("empty_pops", pop_cnt - pops0, 0);
        check("empty_bytes", cap_q.size(), 0);

        // random traffic and random backpressure
        rdy_mode = 2;
        pops0  = pop_cnt;
        cnt0   = model_count;
        pushed = 0;
        for (int n = 0; n < 3000 && pushed < 150; n++) begin
            if ($urandom_range(0, 5) == 0 && fifo_q.size() < 4) begin
                fifo_q.push_back(cmd_packet_t'($urandom));
                pushed++;
                if ($urandom_range(0, 1) == 1) begin
                    fifo_q.push_back(cmd_packet_t'($urandom));
                    pushed++;
                end
                refresh();
            end
            cycle();
        end
        drain(4000);
        check("rand_pops", pop_cnt - pops0, pushed);
        check("rand_count", model_count - cnt0, pushed);

        // no-checksum variant
        begin
            logic [7:0] nb[$];
            logic [39:0] nexp;
            int nsent;
            nexp  = 40'hA5_01_20_FF_01;
            nsent = 0;
            n_valid = 1'b1;
            n_data  = vecs[1].pkt;
            n_ready = 1'b1;
            for (int n = 0; n < 20; n++) begin
                @(negedge clk);
                if (n_tx_valid && n_ready) nb.push_back(n_tx_data);
                if (n_sent) nsent++;
                if (n_rd_en) begin
                    @(posedge clk);
                    #1 n_valid = 1'b0;
                end else begin
                    @(posedge clk);
                    #1;
                end
            end
            check("nochk_len", nb.size(), 5);
            for (int i = 0; i < 5 && i < nb.size(); i++)
                check("nochk_byte", nb[i], nexp[39-8*i -: 8]);
            check("nochk_sent", nsent, 1);
            check("nochk_count", n_count, 16'h0001);
            check("nochk_idle", n_busy, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
